alu_op_scheduler: RTL

//  Shares one multi-cycle 2-operand ALU engine between NREQ requesters over valid/ready.

---
 rtl/alu_sched_pkg.sv | 15 +
 rtl/alu_seq_core.sv | 119 +++++++++++
 rtl/alu_op_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU operation scheduler: opcodes and FSM states.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } sched_state_e;

endpackage

// File: rtl/alu_seq_core.sv
// Iterative ALU engine: single-cycle ADD/SUB, WIDTH-cycle shift-add MUL (LSB first)
// and WIDTH-cycle restoring DIV (MSB first). Operands must stay stable from the
// start cycle until done; the start cycle already performs the first iteration.
module alu_seq_core import alu_sched_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div0
);

  localparam int RES_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic                 run_q, run_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_cur;
  logic [RES_W-1:0]     acc_q, acc_d, acc_cur;
  logic [RES_W-1:0]     mcand_q, mcand_d, mcand_cur;
  logic [WIDTH-1:0]     mplier_q, mplier_d, mplier_cur;
  logic [WIDTH-1:0]     rem_q, rem_d, rem_cur;
  logic [WIDTH-1:0]     dvd_q, dvd_d, dvd_cur;
  logic                 div0_q, div0_d;
  logic                 active;
  logic [WIDTH:0]       rem_sh;
  logic                 rem_ge;

  // One iteration per active cycle; in the start cycle the working values come
  // straight from the operands so no separate load cycle is spent.
  always_comb begin
    run_d      = run_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    div0_d     = div0_q;
    done       = 1'b0;

    active     = start | run_q;
    cnt_cur    = start ? CNT_W'(WIDTH - 1) : cnt_q;
    acc_cur    = start ? '0 : acc_q;
    mcand_cur  = start ? RES_W'(a) : mcand_q;
    mplier_cur = start ? b : mplier_q;
    rem_cur    = start ? '0 : rem_q;
    dvd_cur    = start ? a : dvd_q;

    rem_sh     = {rem_cur, dvd_cur[WIDTH-1]};
    rem_ge     = (rem_sh >= {1'b0, b});

    if (start) begin
      div0_d = (op == OP_DIV) && (b == '0);
    end

    if (active) begin
      cnt_d = (cnt_cur != '0) ? cnt_cur - CNT_W'(1) : '0;
      case (op)
        OP_ADD: begin
          acc_d = RES_W'(a) + RES_W'(b);
          done  = 1'b1;
        end
        OP_SUB: begin
          acc_d = RES_W'(a) - RES_W'(b);
          done  = 1'b1;
        end
        OP_MUL: begin
          acc_d    = mplier_cur[0] ? acc_cur + mcand_cur : acc_cur;
          mcand_d  = mcand_cur << 1;
          mplier_d = mplier_cur >> 1;
          done     = (cnt_cur == '0);
        end
        default: begin
          // b==0 never borrows, so the quotient fills with ones and the
          // remainder ends up holding a.
          rem_d = rem_ge ? WIDTH'(rem_sh - {1'b0, b}) : rem_sh[WIDTH-1:0];
          dvd_d = WIDTH'({dvd_cur, rem_ge});
          done  = (cnt_cur == '0);
        end
      endcase
      run_d = ~done;
    end
  end

  // Working registers; reset aborts any iteration in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      div0_q   <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      div0_q   <= div0_d;
    end
  end

  // Result presentation depends on the operation that produced it.
  always_comb begin
    result = (op == OP_DIV) ? {rem_q, dvd_q} : acc_q;
    div0   = div0_q;
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one iterative ALU engine among NREQ valid/ready requesters, one op in flight.
// Optional feature: define ALU_SCHED_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest index winning.
module alu_op_scheduler import alu_sched_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [WIDTH*NREQ-1:0]     req_a,
  input  logic [WIDTH*NREQ-1:0]     req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*WIDTH-1:0]        rsp_result,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int RES_W = 2 * WIDTH;
  localparam int ID_W  = $clog2(NREQ);

  sched_state_e       state_q, state_d;
  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               accept;

  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               start_q, start_d;

  logic               core_done;
  logic [RES_W-1:0]   core_result;
  logic               core_div0;

`ifdef ALU_SCHED_RR_EN
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    cand;

  // Round-robin: search from the requester after the last one accepted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer advances to the granted index only when the grant is taken.
  always_comb begin
    ptr_d = accept ? grant_idx : ptr_q;
  end

  // Pointer register; resets so that requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= ID_W'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(i);
        grant[i]  = 1'b1;
      end
    end
  end
`endif

  // Next state, request acceptance and capture of the winning request.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    accept  = (state_q == ST_IDLE) && grant_any && !rst;
    start_d = accept;

    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC: if (core_done) state_d = ST_DONE;
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase

    if (accept) begin
      id_d = grant_idx;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          op_d = req_op[2*i +: 2];
          a_d  = req_a[WIDTH*i +: WIDTH];
          b_d  = req_b[WIDTH*i +: WIDTH];
        end
      end
    end
  end

  // FSM state and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      start_q <= start_d;
    end
  end

  alu_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start_q),
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .done   (core_done),
    .result (core_result),
    .div0   (core_div0)
  );

  // Response outputs are only driven while a result is being offered.
  always_comb begin
    req_ready  = accept ? grant : '0;
    rsp_valid  = (state_q == ST_DONE);
    rsp_result = rsp_valid ? core_result : '0;
    rsp_id     = rsp_valid ? id_q : '0;
    rsp_err    = rsp_valid ? core_div0 : 1'b0;
    busy       = (state_q != ST_IDLE);
  end

endmodule
